// File: rtl/mem_wb_access_stage.sv
// MEM/WB access stage: runs a req/ack data-memory access for loads and
// stores, formats load data, and registers the writeback values.
module mem_wb_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWriteM,
   input  logic        MemtoRegM,
   input  logic        MemWriteM,
   input  logic [1:0]  SizeM,
   input  logic        SignedM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  WriteRegM,
   output logic        StallM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic [31:0] ResultW,
   output logic [4:0]  WriteRegW,
   output logic        RegWriteW,
   output logic        AddrErrW,
   output logic        BusErrW
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [31:0]    addr_q;
   logic [1:0]     size_q;
   logic           signed_q;
   logic           we_q;
   logic [31:0]    wdata_q;
   logic           regWrite_q;
   logic [4:0]     writeReg_q;
   logic           abort_q;
   logic [31:0]    loadData_q;

   logic [31:0]    resultW_q, resultW_d;
   logic [4:0]     writeRegW_q, writeRegW_d;
   logic           regWriteW_q, regWriteW_d;
   logic           addrErrW_q, addrErrW_d;
   logic           busErrW_q, busErrW_d;

   logic           isAccess, isMisaligned, startAccess, timeoutHit;
   logic [3:0]     beLane;
   logic [31:0]    wdataLane;
   logic [7:0]     byteLane;
   logic [15:0]    halfLane;
   logic [31:0]    loadFmt;

   // Classify the incoming instruction: memory access or not, and whether its
   // address is legal for the requested size.
   always_comb begin
      isAccess     = MemtoRegM | MemWriteM;
      isMisaligned = ((SizeM == 2'd1) && ALUOutM[0]) ||
                     (SizeM[1] && (ALUOutM[1:0] != 2'b00));
      startAccess  = isAccess & ~isMisaligned;
      timeoutHit   = (cnt_q == CW'(TIMEOUT - 1));
   end

   // Byte enables and lane-replicated store data come from the captured access
   // so the bus stays stable for the whole request.
   always_comb begin
      beLane    = 4'b1111;
      wdataLane = wdata_q;
      case (size_q)
         2'd0: begin
            beLane    = 4'b0001 << addr_q[1:0];
            wdataLane = {4{wdata_q[7:0]}};
         end
         2'd1: begin
            beLane    = addr_q[1] ? 4'b1100 : 4'b0011;
            wdataLane = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   // Pick the addressed lane out of the read word and extend it to 32 bits.
   always_comb begin
      byteLane = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
      halfLane = bus_rdata[{addr_q[1], 4'b0000} +: 16];
      case (size_q)
         2'd0:    loadFmt = {{24{signed_q & byteLane[7]}}, byteLane};
         2'd1:    loadFmt = {{16{signed_q & halfLane[15]}}, halfLane};
         default: loadFmt = bus_rdata;
      endcase
   end

   // State register and access timeout counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: an ack always wins over a timeout firing in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (startAccess) state_d = BUSY;
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (bus_ack || timeoutHit) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stall, bus request and the value each W register loads next; stalled
   // cycles load a bubble.
   always_comb begin
      StallM      = 1'b0;
      bus_req     = 1'b0;
      resultW_d   = '0;
      writeRegW_d = '0;
      regWriteW_d = 1'b0;
      addrErrW_d  = 1'b0;
      busErrW_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (startAccess) begin
               StallM = 1'b1;
            end else if (isAccess) begin
               addrErrW_d = 1'b1;
            end else begin
               resultW_d   = ALUOutM;
               writeRegW_d = WriteRegM;
               regWriteW_d = RegWriteM;
            end
         end
         BUSY: begin
            StallM  = 1'b1;
            bus_req = 1'b1;
         end
         RESP: begin
            if (abort_q) begin
               busErrW_d = 1'b1;
            end else if (!we_q) begin
               resultW_d   = loadData_q;
               writeRegW_d = writeReg_q;
               regWriteW_d = regWrite_q;
            end
         end
         default: ;
      endcase
   end

   // Capture the access when it starts, then the read data or abort outcome.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q     <= '0;
         size_q     <= '0;
         signed_q   <= 1'b0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         regWrite_q <= 1'b0;
         writeReg_q <= '0;
         abort_q    <= 1'b0;
         loadData_q <= '0;
      end else begin
         if (state_q == IDLE && startAccess) begin
            addr_q     <= ALUOutM;
            size_q     <= SizeM;
            signed_q   <= SignedM;
            we_q       <= MemWriteM;
            wdata_q    <= WriteDataM;
            regWrite_q <= RegWriteM;
            writeReg_q <= WriteRegM;
            abort_q    <= 1'b0;
         end
         if (state_q == BUSY) begin
            if (bus_ack) begin
               loadData_q <= loadFmt;
               abort_q    <= 1'b0;
            end else if (timeoutHit) begin
               abort_q <= 1'b1;
            end
         end
      end
   end

   // Writeback pipeline registers load every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         resultW_q   <= '0;
         writeRegW_q <= '0;
         regWriteW_q <= 1'b0;
         addrErrW_q  <= 1'b0;
         busErrW_q   <= 1'b0;
      end else begin
         resultW_q   <= resultW_d;
         writeRegW_q <= writeRegW_d;
         regWriteW_q <= regWriteW_d;
         addrErrW_q  <= addrErrW_d;
         busErrW_q   <= busErrW_d;
      end
   end

   assign bus_we    = we_q;
   assign bus_addr  = {addr_q[31:2], 2'b00};
   assign bus_be    = beLane;
   assign bus_wdata = wdataLane;
   assign ResultW   = resultW_q;
   assign WriteRegW = writeRegW_q;
   assign RegWriteW = regWriteW_q;
   assign AddrErrW  = addrErrW_q;
   assign BusErrW   = busErrW_q;

endmodule

// File: tb/tb_mem_wb_access_stage.sv
// Scoreboard bench for mem_wb_access_stage: directed cases, a reset-mid-access
// case, then random instructions against a behavioural model.
module tb_mem_wb_access_stage;

   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
   } busExp_t;

   typedef struct packed {
      logic        rw;
      logic [4:0]  wreg;
      logic [31:0] result;
      logic        aerr;
      logic        berr;
   } wExp_t;

   logic        clk;
   logic        reset;
   logic        RegWriteM, MemtoRegM, MemWriteM, SignedM;
   logic [1:0]  SizeM;
   logic [31:0] ALUOutM, WriteDataM;
   logic [4:0]  WriteRegM;
   logic        StallM, bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata, ResultW;
   logic [3:0]  bus_be;
   logic [4:0]  WriteRegW;
   logic        RegWriteW, AddrErrW, BusErrW;

   logic        respAck, dirAck, dirMode;
   logic [31:0] respRdata, dirRdata;

   busExp_t busQ[$];
   wExp_t   wQ[$];
   int      assertCount = 0;
   int      failCount = 0;

   assign bus_ack   = respAck | dirAck;
   assign bus_rdata = dirAck ? dirRdata : respRdata;

   mem_wb_access_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
      .SizeM(SizeM), .SignedM(SignedM), .ALUOutM(ALUOutM),
      .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .StallM(StallM),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
      .AddrErrW(AddrErrW), .BusErrW(BusErrW)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: load data extraction by arithmetic on the read word.
   function automatic logic [31:0] expLoad(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] addr, input logic [31:0] rd);
      logic [31:0] v;
      int off;
      off = int'(addr % 4);
      if (sz == 2'd0) begin
         v = (rd >> (8 * off)) & 32'hFF;
         if (sg && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 2'd1) begin
         v = (rd >> (16 * (off / 2))) & 32'hFFFF;
         if (sg && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic logic [3:0] expBe(input logic [1:0] sz, input logic [31:0] addr);
      int off;
      off = int'(addr % 4);
      if (sz == 2'd0) return 4'(1 << off);
      if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] expWdata(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   // Issue one instruction: push model expectations, hold inputs through the
   // stall, and check how many cycles the stage stalled.
   task automatic applyStimulus(input logic rw, input logic mtr, input logic mw,
                                input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [4:0] wr, input int lat, input logic [31:0] rd);
      bit access, misal, done;
      int stalls, expStalls;
      busExp_t b;
      wExp_t w;
      access = mtr || mw;
      misal  = (sz == 2'd1 && (addr % 2) != 0) || (sz >= 2'd2 && (addr % 4) != 0);
      expStalls = 0;
      w = '0;
      if (access && misal) begin
         w.aerr = 1'b1;
         wQ.push_back(w);
      end else if (access) begin
         expStalls = 1 + ((lat == 0) ? TIMEOUT : lat);
         b.addr  = addr & 32'hFFFF_FFFC;
         b.we    = mw;
         b.be    = expBe(sz, addr);
         b.wdata = expWdata(sz, wd);
         b.lat   = lat;
         b.rdata = rd;
         busQ.push_back(b);
         if (lat == 0) begin
            w.berr = 1'b1;
            wQ.push_back(w);
         end else if (!mw && rw) begin
            w.rw = 1'b1; w.wreg = wr; w.result = expLoad(sz, sg, addr, rd);
            wQ.push_back(w);
         end
      end else if (rw) begin
         w.rw = 1'b1; w.wreg = wr; w.result = addr;
         wQ.push_back(w);
      end
      RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw; SizeM = sz; SignedM = sg;
      ALUOutM = addr; WriteDataM = wd; WriteRegM = wr;
      stalls = 0;
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (StallM) stalls++;
         else done = 1'b1;
      end
      if (!done) begin
         failCount++;
         $display("[TB] FAIL stall-bound: StallM still high after 100 cycles, required release");
      end
      checkOutput("stall-cycles", 32'(stalls), 32'(expStalls));
      @(posedge clk); #1;
   endtask

   // Bus responder: checks each request cycle and acks after the chosen latency.
   initial begin
      busExp_t cur;
      int reqCnt;
      bit active;
      cur = '0; reqCnt = 0; active = 1'b0;
      respAck = 1'b0; respRdata = '0;
      forever begin
         @(negedge clk);
         respAck = 1'b0;
         if (dirMode || reset) begin
            active = 1'b0;
            reqCnt = 0;
         end else if (bus_req) begin
            if (!active) begin
               if (busQ.size() == 0) begin
                  checkOutput("unexpected-bus-req", {31'b0, bus_req}, 32'd0);
               end else begin
                  cur = busQ.pop_front();
               end
               active = 1'b1;
               reqCnt = 0;
            end
            reqCnt++;
            checkOutput("bus_addr", bus_addr, cur.addr);
            checkOutput("bus_we", {31'b0, bus_we}, {31'b0, cur.we});
            checkOutput("bus_be", {28'b0, bus_be}, {28'b0, cur.be});
            if (cur.we) checkOutput("bus_wdata", bus_wdata, cur.wdata);
            if (cur.lat != 0 && reqCnt == cur.lat) begin
               respAck = 1'b1;
               respRdata = cur.rdata;
            end
         end else begin
            if (active) begin
               checkOutput("req-cycles", 32'(reqCnt), 32'((cur.lat == 0) ? TIMEOUT : cur.lat));
               active = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
               respAck = 1'b1;
               respRdata = $urandom;
            end
         end
      end
   end

   // Writeback monitor: every visible writeback or error pulse pops the scoreboard.
   initial begin
      wExp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (RegWriteW || AddrErrW || BusErrW)) begin
            if (wQ.size() == 0) begin
               checkOutput("unexpected-w", {29'b0, RegWriteW, AddrErrW, BusErrW}, 32'd0);
            end else begin
               e = wQ.pop_front();
               checkOutput("w-flags", {29'b0, RegWriteW, AddrErrW, BusErrW},
                           {29'b0, e.rw, e.aerr, e.berr});
               if (e.rw) begin
                  checkOutput("ResultW", ResultW, e.result);
                  checkOutput("WriteRegW", {27'b0, WriteRegW}, {27'b0, e.wreg});
               end
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence.
   initial begin
      logic [1:0] sz;
      logic [31:0] addr;
      int kind, r, lat;
      reset = 1'b1; dirMode = 1'b0; dirAck = 1'b0; dirRdata = '0;
      RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; SizeM = 0; SignedM = 0;
      ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset-StallM", {31'b0, StallM}, 32'd0);
      checkOutput("reset-bus_req", {31'b0, bus_req}, 32'd0);
      checkOutput("reset-W", {ResultW[31:8], ResultW[7:0] | {WriteRegW, RegWriteW, AddrErrW, BusErrW}}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      applyStimulus(1, 0, 0, 2'd2, 0, 32'h0000_1234, 32'h0, 5'd8, 0, 32'h0);
      applyStimulus(1, 1, 0, 2'd0, 1, 32'h0000_0103, 32'h0, 5'd9, 1, 32'h80AB_CDEF);
      applyStimulus(0, 0, 1, 2'd1, 0, 32'h0000_0202, 32'h0000_BEEF, 5'd0, 3, 32'h0);
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h0000_0301, 32'h0, 5'd10, 1, 32'h0);
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h0000_0500, 32'h0, 5'd11, 0, 32'h0);
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h0000_0504, 32'h0, 5'd12, TIMEOUT, 32'hCAFE_F00D);
      applyStimulus(1, 1, 0, 2'd1, 0, 32'h0000_0602, 32'h0, 5'd13, 2, 32'h8001_7FFE);

      // Reset during the second BUSY cycle, with a late ack afterwards.
      dirMode = 1'b1;
      RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0; SizeM = 2'd2; SignedM = 0;
      ALUOutM = 32'h0000_0400; WriteRegM = 5'd5;
      @(negedge clk);
      checkOutput("rst-idle-stall", {31'b0, StallM}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst-busy1-req", {31'b0, bus_req}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      RegWriteM = 0; MemtoRegM = 0; ALUOutM = '0; WriteRegM = '0;
      dirAck = 1'b1; dirRdata = 32'h1234_5678;
      @(negedge clk);
      checkOutput("rst-req-dropped", {31'b0, bus_req}, 32'd0);
      checkOutput("rst-stall", {31'b0, StallM}, 32'd0);
      checkOutput("rst-ResultW", ResultW, 32'd0);
      checkOutput("rst-wflags", {24'b0, WriteRegW, RegWriteW, AddrErrW, BusErrW}, 32'd0);
      @(posedge clk); #1;
      dirAck = 1'b0;
      @(negedge clk);
      checkOutput("late-ack-req", {31'b0, bus_req}, 32'd0);
      checkOutput("late-ack-w", {24'b0, WriteRegW, RegWriteW, AddrErrW, BusErrW}, 32'd0);
      @(posedge clk); #1;
      dirMode = 1'b0;
      applyStimulus(1, 1, 0, 2'd0, 0, 32'h0000_0401, 32'h0, 5'd6, 1, 32'h00C3_0000);
      applyStimulus(1, 0, 0, 2'd0, 0, 32'h0BAD_F00D, 32'h0, 5'd7, 0, 32'h0);

      // Random instructions.
      for (int i = 0; i < 200; i++) begin
         kind = $urandom_range(0, 9);
         sz = 2'($urandom_range(0, 3));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr & ((sz == 2'd0) ? 32'hFFFF_FFFF :
                                                      (sz == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
         r = $urandom_range(0, 9);
         lat = (r == 0) ? 0 : (r == 1) ? TIMEOUT : (r == 2) ? $urandom_range(5, 15) : $urandom_range(1, 4);
         applyStimulus(1'($urandom_range(0, 1)), (kind >= 3 && kind <= 5) || kind == 9,
                       kind >= 6, sz, 1'($urandom_range(0, 1)), addr, $urandom,
                       5'($urandom_range(0, 31)), lat, $urandom);
      end

      RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("w-scoreboard-drained", 32'(wQ.size()), 32'd0);
      checkOutput("bus-scoreboard-drained", 32'(busQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_wb_access_stage.md
Name: mem_wb_access_stage

Overview:
- Sequential stage directly downstream of the MIPS memory stage. Consumes its ALU result, store data, destination register and MemWrite/MemtoReg/RegWrite controls.
- Drives a variable-latency data-memory bus with a req/ack handshake and byte enables. Formats load data (byte/half/word, signed/unsigned).
- Acts as the MEM/WB pipeline register: stalls the pipeline while a bus access is outstanding and presents registered writeback values.

Parameters:
- TIMEOUT, 16, maximum cycles bus_req may wait for bus_ack before the access is aborted (must be ≥ 2).

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- RegWriteM  input  1  instruction writes the register file
- MemtoRegM  input  1  instruction is a load
- MemWriteM  input  1  instruction is a store
- SizeM  input  2  access size: 0 byte, 1 half, 2 word, 3 treated as word
- SignedM  input  1  sign-extend sub-word loads
- ALUOutM  input  32  effective address, or result for non-memory instructions
- WriteDataM  input  32  store data, low bytes significant
- WriteRegM  input  5  destination register
- StallM  output  1  hold all upstream stages this cycle
- bus_req  output  1  access request, held until ack or abort
- bus_we  output  1  1 = write
- bus_addr  output  32  word-aligned address, {ALUOutM[31:2],2'b00}
- bus_be  output  4  byte enables, little-endian
- bus_wdata  output  32  lane-replicated store data
- bus_ack  input  1  access complete; bus_rdata valid this cycle for reads
- bus_rdata  input  32  read word
- ResultW  output  32  formatted load data or ALU result
- WriteRegW  output  5  destination register
- RegWriteW  output  1  register-file write enable
- AddrErrW  output  1  one-cycle pulse: misaligned access dropped
- BusErrW  output  1  one-cycle pulse: access aborted on timeout

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, all W outputs 0, bus_req 0, timeout counter 0, StallM 0.
- Access = MemtoRegM | MemWriteM. Both set at once is treated as a store.
- Misaligned when: half with ALUOutM[0] = 1, or word with ALUOutM[1:0] ≠ 0.
- States:
  - IDLE:
    - Aligned access: StallM = 1, go to BUSY. No bus_req in this cycle.
    - Misaligned access: no bus activity, no stall. Next cycle AddrErrW = 1 and RegWriteW = 0.
    - No access: no stall. Next cycle ResultW = ALUOutM, WriteRegW = WriteRegM, RegWriteW = RegWriteM.
  - BUSY:
    - bus_req = 1, with bus_addr/we/be/wdata stable and derived from the held M inputs. StallM = 1. Counter increments each cycle.
    - On bus_ack: capture the formatted read data, go to RESP. bus_req drops the next cycle.
    - When the counter reaches TIMEOUT-1 without ack: go to RESP with abort flagged.
  - RESP:
    - StallM = 0, so the pipeline advances at the end of this cycle. Return to IDLE.
    - Next cycle's W outputs: load → captured data with RegWriteW = RegWriteM; store → RegWriteW = 0; abort → RegWriteW = 0 and BusErrW = 1.
- Minimum latency: a memory instruction occupies 3 cycles in this stage (IDLE, BUSY with same-cycle ack, RESP). Its W outputs appear on the edge after RESP.
- W registers load every cycle. While StallM = 1 they load a bubble: RegWriteW = 0, WriteRegW = 0, ResultW = 0, error flags 0.
- Byte enables:
  - Byte: be = 1 << addr[1:0]; wdata = 4 copies of WriteDataM[7:0].
  - Half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = 2 copies of WriteDataM[15:0].
  - Word: be = 4'b1111; wdata = WriteDataM.
  - Reads drive the same bus_be pattern.
- Load format:
  - Byte: lane = bus_rdata >> (8·addr[1:0]), then the low 8 bits.
  - Half: lane = bus_rdata >> (16·addr[1]), then the low 16 bits.
  - Zero- or sign-extend to 32 bits per SignedM.
- Boundaries:
  - bus_ack outside BUSY is ignored.
  - Ack in the same cycle the timeout fires counts as success.
  - Reset mid-BUSY: bus_req = 0 the next cycle, state IDLE, no W pulse. A late ack is ignored.
  - Counter clears on entering BUSY.

Test Plan:
- ALU op, ALUOutM = 0x0000_1234, WriteRegM = 8, RegWriteM = 1, no access → next cycle ResultW = 0x1234, WriteRegW = 8, RegWriteW = 1, StallM never 1.
- lb signed at 0x103, bus_rdata = 0x80AB_CDEF, ack in the first BUSY cycle → bus_be = 4'b1000, bus_addr = 0x100, StallM high 2 cycles, ResultW = 0xFFFF_FF80.
- sh at 0x202, WriteDataM = 0x0000_BEEF, ack after 3 BUSY cycles → bus_we = 1, bus_be = 4'b1100, bus_wdata = 0xBEEF_BEEF, RegWriteW = 0, StallM high 4 cycles.
- lw at 0x301 → no bus_req, no stall, AddrErrW = 1 for one cycle, RegWriteW = 0.
- lw, ack never arrives, TIMEOUT = 16 → bus_req high exactly 16 cycles, then BusErrW = 1 for one cycle, RegWriteW = 0, pipeline resumes.
- Reset asserted in the 2nd BUSY cycle, bus_ack pulsed 1 cycle later → bus_req 0, all W outputs 0, no writeback pulse, next instruction is accepted normally.
